// File: rtl/irq_controller.sv
// irq_controller: fixed-priority interrupt dispatcher for the program sequencer.
// Optional IRQ_LEVEL_EN: level-sensitive pending instead of edge capture.
module irq_controller #(
   parameter int         NUM_IRQ  = 4,
   parameter logic [3:0] VEC_BASE = 4'h8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               global_en,
   input  logic [7:0]         pc,
   input  logic               prog_jmp,
   input  logic               seq_hold,
   input  logic               rti,
   output logic               irq_jmp,
   output logic [3:0]         irq_jmp_addr,
   output logic               ret_load,
   output logic [7:0]         ret_addr,
   output logic [NUM_IRQ-1:0] ack,
   output logic               active,
   output logic [2:0]         active_id,
   output logic               rti_err
);

   typedef enum logic {IDLE, SERVICE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] eligible;
   logic [2:0]         winner;
   logic               take;

`ifdef IRQ_LEVEL_EN
   assign pending = irq;
`else
   logic [NUM_IRQ-1:0] irq_q;

   // a new edge wins over an ack clear of the same bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q   <= '0;
         pending <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~ack) | (irq & ~irq_q);
      end
   end
`endif

   assign eligible = pending & irq_mask;

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (eligible[i]) winner = 3'(i);
   end

   assign take = (state == IDLE) & global_en & (|eligible)
               & ~prog_jmp & ~seq_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      irq_jmp      = 1'b0;
      irq_jmp_addr = '0;
      ack          = '0;
      ret_load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (take) begin
               state_nxt    = SERVICE;
               irq_jmp      = 1'b1;
               irq_jmp_addr = VEC_BASE + {1'b0, winner};
               ack          = NUM_IRQ'(1) << winner;
            end
         end
         SERVICE: begin
            if (rti) begin
               ret_load  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign active = (state == SERVICE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_id <= '0;
         ret_addr  <= '0;
         rti_err   <= 1'b0;
      end else begin
         if (take) begin
            active_id <= winner;
            ret_addr  <= pc + 8'd1;
         end
         if (rti && state == IDLE) rti_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: vector table, corner sequences and randomized
// run against a behavioural model of the interrupt dispatcher.
module tb_irq_controller;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] irq = '0;
   logic [N-1:0] irq_mask = '0;
   logic         global_en = 1'b0;
   logic [7:0]   pc = '0;
   logic         prog_jmp = 1'b0;
   logic         seq_hold = 1'b0;
   logic         rti = 1'b0;
   logic         irq_jmp;
   logic [3:0]   irq_jmp_addr;
   logic         ret_load;
   logic [7:0]   ret_addr;
   logic [N-1:0] ack;
   logic         active;
   logic [2:0]   active_id;
   logic         rti_err;

   int checks = 0;
   int failures = 0;

   irq_controller #(.NUM_IRQ(N), .VEC_BASE(4'h8)) dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .irq_mask(irq_mask),
      .global_en(global_en), .pc(pc), .prog_jmp(prog_jmp),
      .seq_hold(seq_hold), .rti(rti), .irq_jmp(irq_jmp),
      .irq_jmp_addr(irq_jmp_addr), .ret_load(ret_load),
      .ret_addr(ret_addr), .ack(ack), .active(active),
      .active_id(active_id), .rti_err(rti_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  irq;
      logic [3:0]  mask;
      logic        ge;
      logic [7:0]  pc;
      logic        pj;
      logic        sh;
      logic        rti;
      logic [22:0] exp;
   } vec_t;

   function automatic logic [22:0] pk(logic j, logic [3:0] a, logic [3:0] k,
                                      logic rl, logic [7:0] ra, logic act,
                                      logic [2:0] id, logic err);
      return {j, a, k, rl, ra, act, id, err};
   endfunction

   function automatic vec_t v(logic [3:0] i, logic [3:0] m, logic g,
                              logic [7:0] p, logic pj, logic sh, logic r,
                              logic [22:0] e);
      vec_t t;
      t.irq = i; t.mask = m; t.ge = g; t.pc = p;
      t.pj = pj; t.sh = sh; t.rti = r; t.exp = e;
      return t;
   endfunction

   task automatic check(string name, logic [22:0] exp);
      logic [22:0] got;
      got = {irq_jmp, irq_jmp_addr, ack, ret_load, ret_addr,
             active, active_id, rti_err};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (jmp,addr,ack,rl,ret,act,id,err)",
                  name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      irq = '0; irq_mask = '0; global_en = 1'b0; pc = '0;
      prog_jmp = 1'b0; seq_hold = 1'b0; rti = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      check("reset_state", '0);
      reset_n = 1'b1;
   endtask

   vec_t tbl[$];

   bit [N-1:0] m_q, m_pend, elig;
   bit         m_busy, m_err, tk;
   int         m_id, win;
   bit [7:0]   m_ret;

   initial begin
      do_reset();

`ifndef IRQ_LEVEL_EN
      tbl.push_back(v(4'h4, 4'hF, 1, 8'h23, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h23, 0, 0, 0, pk(1, 4'hA, 4'h4, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h23, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h24, 1, 2, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h23, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h24, 1, 2, 0)));
      tbl.push_back(v(4'hA, 4'hF, 1, 8'h23, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h24, 0, 2, 0)));
      tbl.push_back(v(4'hA, 4'hF, 1, 8'h30, 0, 0, 0, pk(1, 4'h9, 4'h2, 0, 8'h24, 0, 2, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h40, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h31, 1, 1, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h50, 0, 0, 0, pk(1, 4'hB, 4'h8, 0, 8'h31, 0, 1, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h51, 1, 3, 0)));
      tbl.push_back(v(4'h1, 4'hF, 1, 8'hFF, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h51, 0, 3, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 1, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h51, 0, 3, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 1, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h51, 0, 3, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 1, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h51, 0, 3, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 0, 0, 0, pk(1, 4'h8, 4'h1, 0, 8'h51, 0, 3, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'hFF, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h00, 1, 0, 0)));
      tbl.push_back(v(4'h4, 4'hB, 1, 8'h10, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hB, 1, 8'h10, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h10, 0, 1, 0, pk(0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h10, 0, 0, 0, pk(1, 4'hA, 4'h4, 0, 8'h00, 0, 0, 0)));
      tbl.push_back(v(4'h1, 4'h0, 0, 8'h10, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h11, 1, 2, 0)));
      tbl.push_back(v(4'h0, 4'h0, 0, 8'h10, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h11, 1, 2, 0)));
      tbl.push_back(v(4'h0, 4'hF, 0, 8'h10, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h11, 0, 2, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h07, 0, 0, 0, pk(1, 4'h8, 4'h1, 0, 8'h11, 0, 2, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h07, 0, 0, 1, pk(0, 4'h0, 4'h0, 1, 8'h08, 1, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h07, 0, 0, 1, pk(0, 4'h0, 4'h0, 0, 8'h08, 0, 0, 0)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h07, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h08, 0, 0, 1)));
      tbl.push_back(v(4'h0, 4'hF, 1, 8'h07, 0, 0, 0, pk(0, 4'h0, 4'h0, 0, 8'h08, 0, 0, 1)));

      foreach (tbl[r]) begin
         irq = tbl[r].irq; irq_mask = tbl[r].mask; global_en = tbl[r].ge;
         pc = tbl[r].pc; prog_jmp = tbl[r].pj; seq_hold = tbl[r].sh;
         rti = tbl[r].rti;
         #2;
         check($sformatf("table_row%0d", r), tbl[r].exp);
         step();
      end

      // line already high when reset releases counts as an edge
      idle_inputs();
      reset_n = 1'b0;
      irq = 4'h1; global_en = 1'b1; irq_mask = 4'hF; pc = 8'h60;
      step();
      reset_n = 1'b1;
      #2;
      check("release_no_take", '0);
      step();
      check("release_edge_take", pk(1, 4'h8, 4'h1, 0, 8'h00, 0, 0, 0));
      step();
      check("held_line_once", pk(0, 4'h0, 4'h0, 0, 8'h61, 1, 0, 0));
      rti = 1'b1;
      step();
      rti = 1'b0;
      #2;
      check("held_line_no_redispatch", pk(0, 4'h0, 4'h0, 0, 8'h61, 0, 0, 0));
`else
      global_en = 1'b1; irq_mask = 4'hF; irq = 4'h1; pc = 8'h20;
      #2;
      check("level_take", pk(1, 4'h8, 4'h1, 0, 8'h00, 0, 0, 0));
      step();
      rti = 1'b1;
      #2;
      check("level_rti", pk(0, 4'h0, 4'h0, 1, 8'h21, 1, 0, 0));
      step();
      rti = 1'b0; pc = 8'h44;
      #2;
      check("level_redispatch", pk(1, 4'h8, 4'h1, 0, 8'h21, 0, 0, 0));
      step();
      check("level_service2", pk(0, 4'h0, 4'h0, 0, 8'h45, 1, 0, 0));
`endif

      // reset asserted mid-service
      do_reset();
      global_en = 1'b1; irq_mask = 4'hF; irq = 4'h2; pc = 8'h70;
      step();
      #2;
      check("mid_take", pk(1, 4'h9, 4'h2, 0, 8'h00, 0, 0, 0));
      step();
      irq = 4'h8;
      step();
      irq = 4'h0;
      #2;
      check("mid_service", pk(0, 4'h0, 4'h0, 0, 8'h71, 1, 1, 0));
      reset_n = 1'b0;
      #1;
      check("mid_reset_async", '0);
      step();
      reset_n = 1'b1;
      #2;
      check("post_reset_idle0", '0);
      step();
      check("post_reset_idle1", '0);

      // randomized run against the model
      do_reset();
      m_q = '0; m_pend = '0; m_busy = 0; m_err = 0; m_id = 0; m_ret = '0;
      for (int c = 0; c < 2000; c++) begin
         irq = (($urandom % 3) == 0) ? N'($urandom) : irq;
         irq_mask = (($urandom % 8) == 0) ? N'($urandom) : irq_mask;
         global_en = ($urandom % 5) != 0;
         pc = 8'($urandom);
         prog_jmp = ($urandom % 4) == 0;
         seq_hold = ($urandom % 6) == 0;
         rti = ($urandom % 5) == 0;
         #2;
`ifdef IRQ_LEVEL_EN
         elig = irq & irq_mask;
`else
         elig = m_pend & irq_mask;
`endif
         win = -1;
         for (int i = 0; i < N; i++)
            if (elig[i] && win < 0) win = i;
         tk = !m_busy && global_en && win >= 0 && !prog_jmp && !seq_hold;
         check("random",
               pk(tk, tk ? 4'(8 + win) : 4'h0, tk ? 4'(1 << win) : 4'h0,
                  m_busy && rti, m_ret, m_busy, 3'(m_id), m_err));
`ifndef IRQ_LEVEL_EN
         m_pend = (m_pend & ~(tk ? N'(1 << win) : N'(0))) | (irq & ~m_q);
         m_q = irq;
`endif
         if (!m_busy && rti) m_err = 1;
         if (tk) begin
            m_busy = 1; m_id = win; m_ret = pc + 8'd1;
         end else if (m_busy && rti) begin
            m_busy = 0;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
